// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto the single-ported
// shared data bank, one access in flight, with per-core ack pulse and held read data.
module shared_mem_arbiter #(
  parameter int unsigned Ncores = 2,
  parameter int unsigned Lmem   = 8,
  parameter int unsigned TAM    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Ncores-1:0]     core_req,
  input  logic [Ncores-1:0]     core_we,
  input  logic [Ncores*TAM-1:0] core_addr,
  input  logic [Ncores*TAM-1:0] core_wdata,
  output logic [Ncores-1:0]     core_ack,
  output logic [Ncores*TAM-1:0] core_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [Lmem-1:0]       mem_addr,
  output logic [TAM-1:0]        mem_wdata,
  input  logic [TAM-1:0]        mem_rdata,
  output logic                  busy
);

  localparam int unsigned PW = (Ncores > 1) ? $clog2(Ncores) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]         r_win, w_win_nxt;
  logic [Ncores-1:0]     r_mask, w_mask_nxt;
  logic [Ncores-1:0]     r_ack, w_ack_nxt;
  logic [Ncores*TAM-1:0] r_rdata, w_rdata_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [Lmem-1:0]       r_mem_addr, w_mem_addr_nxt;
  logic [TAM-1:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_busy, w_busy_nxt;

  logic [Ncores-1:0]     w_elig;
  logic [PW-1:0]         w_cand;
  logic [PW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_unused;

  // Address bits above the bank width are don't-care.
  assign w_unused = ^core_addr;

  // Round-robin pick: the loop visits rr_ptr+Ncores down to rr_ptr+1, so the last hit wins
  // and rr_ptr+1 has highest priority.
  always_comb begin
    w_elig  = core_req & ~r_mask;
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_cand  = '0;
    for (int unsigned k = 0; k < Ncores; k++) begin
      w_cand = PW'((32'(r_rr_ptr) + Ncores - k) % Ncores);
      if (w_elig[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_win_nxt       = r_win;
    w_mask_nxt      = r_mask;
    w_ack_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      IDLE: begin
        w_mask_nxt = '0;
        if (w_found) begin
          w_win_nxt       = w_pick;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = core_we[w_pick];
          w_mem_addr_nxt  = core_addr[32'(w_pick)*TAM +: Lmem];
          w_mem_wdata_nxt = core_wdata[32'(w_pick)*TAM +: TAM];
          w_state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (r_mem_we) begin
          w_ack_nxt[r_win] = 1'b1;
          w_state_nxt      = ACK;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_rdata_nxt[32'(r_win)*TAM +: TAM] = mem_rdata;
        w_ack_nxt[r_win]                   = 1'b1;
        w_state_nxt                        = ACK;
      end
      ACK: begin
        // Mask the winner for one IDLE cycle so a late-dropped request is not regranted.
        w_rr_ptr_nxt      = r_win;
        w_mask_nxt        = '0;
        w_mask_nxt[r_win] = 1'b1;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= PW'(Ncores - 1);
      r_win       <= '0;
      r_mask      <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_win       <= w_win_nxt;
      r_mask      <= w_mask_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign core_ack   = r_ack;
  assign core_rdata = r_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: per-cycle vector table plus hand sequences
// for fair arbitration and address latching, against a behavioural bank model.
module tb_shared_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  core_req;
  logic [1:0]  core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_ack;
  logic [31:0] core_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  logic [15:0] bank [256];

  int checks;
  int errors;

  shared_mem_arbiter #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported bank: write on strobe, read data valid the following cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bank[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bank[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    logic [1:0]  ack;
    logic        en;
    logic        mwe;
    logic [7:0]  maddr;
    logic [15:0] mwdata;
    logic        busy;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int exp_order[4];
    int na;
    int ng;
    int idx;
    logic prev_en;

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;

    // rst req we a0 a1 wd0 wd1 | ack en mwe maddr mwdata busy rd0 rd1
    vq.push_back('{1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    // core0 store 0x0105 <- 0xBEEF
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'h0105, 16'h0000, 16'hBEEF, 16'h0000, 2'b00, 1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'h0105, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 1'b0, 1'b0, 8'h05, 16'hBEEF, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 2'b00, 16'h0105, 16'h0000, 16'hBEEF, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h05, 16'hBEEF, 1'b0, 16'h0000, 16'h0000});
    // core1 load 0x0105 -> 0xBEEF
    vq.push_back('{1'b0, 2'b10, 2'b00, 16'h0000, 16'h0105, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b10, 2'b00, 16'h0000, 16'h0105, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b10, 2'b00, 16'h0000, 16'h0105, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0105, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 16'hBEEF});
    // core0 store with high address bits set, then holds req one cycle past its ack
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'hFFA7, 16'h0000, 16'h1234, 16'h0000, 2'b00, 1'b1, 1'b1, 8'hA7, 16'h1234, 1'b1, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'hFFA7, 16'h0000, 16'h1234, 16'h0000, 2'b01, 1'b0, 1'b0, 8'hA7, 16'h1234, 1'b1, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'hFFA7, 16'h0000, 16'h1234, 16'h0000, 2'b00, 1'b0, 1'b0, 8'hA7, 16'h1234, 1'b0, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b0, 2'b01, 2'b01, 16'hFFA7, 16'h0000, 16'h1234, 16'h0000, 2'b00, 1'b0, 1'b0, 8'hA7, 16'h1234, 1'b0, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'hA7, 16'h1234, 1'b0, 16'h0000, 16'hBEEF});
    // core1 load, reset for two cycles while it is in flight
    vq.push_back('{1'b0, 2'b10, 2'b00, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 16'h0000, 16'hBEEF});
    vq.push_back('{1'b1, 2'b10, 2'b00, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b1, 2'b10, 2'b00, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    vq.push_back('{1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 16'h0000});

    foreach (vq[i]) begin
      rst        = vq[i].rst;
      core_req   = vq[i].req;
      core_we    = vq[i].we;
      core_addr  = {vq[i].a1, vq[i].a0};
      core_wdata = {vq[i].wd1, vq[i].wd0};
      step();
      chk($sformatf("v%0d_ack", i), 32'(core_ack), 32'(vq[i].ack));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vq[i].en));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("v%0d_rdata0", i), 32'(core_rdata[15:0]), 32'(vq[i].rd0));
      chk($sformatf("v%0d_rdata1", i), 32'(core_rdata[31:16]), 32'(vq[i].rd1));
      if (vq[i].en || vq[i].rst) begin
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vq[i].mwe));
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vq[i].maddr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vq[i].mwdata));
      end
    end

    // Both cores request continuously from reset: grants alternate starting with core0.
    rst = 1'b1;
    core_req = '0;
    step();
    rst        = 1'b0;
    core_req   = 2'b11;
    core_we    = 2'b11;
    core_addr  = {16'h0041, 16'h0040};
    core_wdata = {16'hA5A5, 16'h5A5A};
    exp_order  = '{0, 1, 0, 1};
    na = 0;
    ng = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 40 && na < 4; c++) begin
      step();
      if (mem_en) begin
        chk($sformatf("rr_no_back2back_%0d", ng), 32'(prev_en), 32'd0);
        if (ng < 4)
          chk($sformatf("rr_addr_%0d", ng), 32'(mem_addr), (exp_order[ng] == 0) ? 32'h40 : 32'h41);
        ng++;
      end
      prev_en = mem_en;
      if (core_ack != 2'b00) begin
        chk($sformatf("rr_onehot_%0d", na), 32'($onehot(core_ack)), 32'd1);
        idx = core_ack[1] ? 1 : 0;
        chk($sformatf("rr_order_%0d", na), 32'(idx), 32'(exp_order[na]));
        na++;
      end
    end
    chk("rr_ack_count", 32'(na), 32'd4);
    core_req = 2'b00;
    step();
    step();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Core1 load of 0x40; address changes during WAIT must not affect the access.
    core_req  = 2'b10;
    core_we   = 2'b00;
    core_addr = {16'h0040, 16'h0000};
    step();
    chk("latch_issue_en", 32'(mem_en), 32'd1);
    chk("latch_issue_we", 32'(mem_we), 32'd0);
    chk("latch_issue_addr", 32'(mem_addr), 32'h40);
    step();
    chk("latch_wait_en", 32'(mem_en), 32'd0);
    core_addr = {16'h0041, 16'h0000};
    step();
    chk("latch_ack", 32'(core_ack), 32'b10);
    chk("latch_rdata1", 32'(core_rdata[31:16]), 32'h5A5A);
    chk("latch_rdata0", 32'(core_rdata[15:0]), 32'h0000);
    chk("latch_addr_held", 32'(mem_addr), 32'h40);
    core_req = 2'b00;
    step();
    chk("latch_ack_pulse", 32'(core_ack), 32'b00);
    chk("latch_busy", 32'(busy), 32'd0);
    chk("latch_rdata1_held", 32'(core_rdata[31:16]), 32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
